// File: rtl/hamming74_pkg.sv
// Shared Hamming(7,4) definitions: codeword positions, FSM encoding, syndrome.
// Used by both the serial encoder and the serial receive decoder.
package hamming74_pkg;

    localparam int CW_W   = 7;
    localparam int POS_P1 = 1;
    localparam int POS_P2 = 2;
    localparam int POS_D1 = 3;
    localparam int POS_P3 = 4;
    localparam int POS_D2 = 5;
    localparam int POS_D3 = 6;
    localparam int POS_D4 = 7;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Syndrome {s3,s2,s1}; a nonzero value is the position of a single flip.
    function automatic logic [2:0] syndrome(input logic [CW_W:1] cw);
        logic s1;
        logic s2;
        logic s3;
        s1 = cw[1] ^ cw[3] ^ cw[5] ^ cw[7];
        s2 = cw[2] ^ cw[3] ^ cw[6] ^ cw[7];
        s3 = cw[4] ^ cw[5] ^ cw[6] ^ cw[7];
        return {s3, s2, s1};
    endfunction

endpackage

// File: rtl/hamming74_correct.sv
// Combinational single-error correction of a 7-bit Hamming codeword.
// Outputs the corrected data nibble {d1,d2,d3,d4} and a corrected flag.
module hamming74_correct
    import hamming74_pkg::*;
(
    input  logic [CW_W:1] cw,
    output logic [3:0]    nibble,
    output logic          err
);

    logic [2:0]    s;
    logic [CW_W:1] fixed;

    // Flip the bit addressed by the syndrome, if any, then pick data bits.
    always_comb begin
        s     = syndrome(cw);
        fixed = cw;
        for (int i = 1; i <= CW_W; i++) begin
            fixed[i] = cw[i] ^ (s == 3'(i));
        end
        nibble = {fixed[POS_D1], fixed[POS_D2], fixed[POS_D3], fixed[POS_D4]};
        err    = |s;
    end

endmodule

// File: rtl/hamming74_rx_decode.sv
// Serial Hamming(7,4) receive decoder: deserialise, correct, present nibble.
// Optional corrected-frame counter enabled by macro HAMMING_RX_ERRCNT_EN.
module hamming74_rx_decode
    import hamming74_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             frame_start,
    output logic [3:0]       out,
    output logic             out_valid,
    output logic             err_fix,
    output logic             sync_err,
    output logic [CNT_W-1:0] err_cnt
);

    state_t        state_q;
    state_t        state_d;
    logic [2:0]    idx_q;
    logic [2:0]    idx_d;
    logic [CW_W:1] cw_q;
    logic [CW_W:1] cw_d;
    logic          done_d;
    logic          sync_d;
    logic [3:0]    nibble;
    logic          fix;

    logic [3:0]    out_q;
    logic          out_valid_q;
    logic          err_fix_q;
    logic          sync_err_q;

    // The decoder sees the word including the bit captured this cycle.
    hamming74_correct u_correct (
        .cw     (cw_d),
        .nibble (nibble),
        .err    (fix)
    );

    // Next-state: frame capture, index advance, abort on early frame_start.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cw_d    = cw_q;
        done_d  = 1'b0;
        sync_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid && frame_start) begin
                    cw_d         = '0;
                    cw_d[POS_P1] = in_bit;
                    idx_d        = 3'd2;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                if (in_valid) begin
                    if (frame_start) begin
                        sync_d       = 1'b1;
                        cw_d         = '0;
                        cw_d[POS_P1] = in_bit;
                        idx_d        = 3'd2;
                    end else begin
                        cw_d[idx_q] = in_bit;
                        if (idx_q == 3'(POS_D4)) begin
                            done_d  = 1'b1;
                            idx_d   = 3'd0;
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    // State, index and shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cw_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cw_q    <= cw_d;
        end
    end

    // Registered outputs; out holds until the next completed frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q       <= 4'd0;
            out_valid_q <= 1'b0;
            err_fix_q   <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            if (done_d) begin
                out_q <= nibble;
            end
            out_valid_q <= done_d;
            err_fix_q   <= done_d & fix;
            sync_err_q  <= sync_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign err_fix   = err_fix_q;
    assign sync_err  = sync_err_q;

`ifdef HAMMING_RX_ERRCNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of corrected frames, updated alongside err_fix.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (done_d && fix && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign err_cnt = cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_hamming74_rx_decode.sv
// Scoreboard bench for hamming74_rx_decode with directed frames.
// Driver pushes expected results; a monitor pops them on each out_valid.
module tb_hamming74_rx_decode;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_bit;
    logic             in_valid;
    logic             frame_start;
    logic [3:0]       out;
    logic             out_valid;
    logic             err_fix;
    logic             sync_err;
    logic [CNT_W-1:0] err_cnt;

    typedef struct {
        logic [3:0]       nib;
        logic             fix;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   sync_seen = 0;
    int   pushes = 0;
    int   model_cnt = 0;

    hamming74_rx_decode #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .frame_start (frame_start),
        .out         (out),
        .out_valid   (out_valid),
        .err_fix     (err_fix),
        .sync_err    (sync_err),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a result.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (sync_err) sync_seen++;
            if (out_valid) begin
                vq.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out", int'(out), int'(e.nib));
                    chk("err_fix", int'(err_fix), int'(e.fix));
                    chk("err_cnt", int'(err_cnt), int'(e.cnt));
                end
            end
        end
    end

    task automatic drive_bit(input logic b, input logic fs);
        in_valid    = 1'b1;
        in_bit      = b;
        frame_start = fs;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic gap(input int n, input logic junk);
        for (int k = 0; k < n; k++) begin
            in_valid    = 1'b0;
            in_bit      = junk;
            frame_start = 1'b1;
            @(posedge clk);
            #1;
            frame_start = 1'b0;
        end
    endtask

    // f is written pos1..pos7 left to right.
    task automatic send_frame(input logic [6:0] f, input logic [3:0] nib,
                              input logic fix, input int gmax);
        exp_t e;
        for (int i = 6; i >= 0; i--) begin
            if (i == 0) begin
                if (fix) begin
`ifdef HAMMING_RX_ERRCNT_EN
                    if (model_cnt < 3) model_cnt++;
`endif
                end
                e.nib = nib;
                e.fix = fix;
                e.cnt = CNT_W'(model_cnt);
                exp_q.push_back(e);
                pushes++;
            end
            drive_bit(f[i], i == 6);
            if (gmax > 0 && i > 0) gap($urandom_range(0, gmax), ~f[i-1]);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] part;
        rst_n       = 1'b0;
        in_bit      = 1'b0;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", int'(out), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_err_fix", int'(err_fix), 0);
        chk("rst_sync_err", int'(sync_err), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: clean frame
        send_frame(7'b0110011, 4'b1011, 1'b0, 0);
        drain("t1_drain");

        // 2: pos5 flipped
        send_frame(7'b0110111, 4'b1011, 1'b1, 0);
        drain("t2_drain");

        // 3: back-to-back, no gap
        send_frame(7'b0000000, 4'b0000, 1'b0, 0);
        send_frame(7'b1111111, 4'b1111, 1'b0, 0);
        drain("t3_drain");
        chk("t3_spacing", vq[vq.size()-1] - vq[vq.size()-2], 7);

        // 4: partial frame aborted by early frame_start
        part = 7'b0110011;
        drive_bit(part[6], 1'b1);
        drive_bit(part[5], 1'b0);
        drive_bit(part[4], 1'b0);
        send_frame(7'b1111111, 4'b1111, 1'b0, 0);
        drain("t4_drain");
        chk("t4_sync_count", sync_seen, 1);

        // 5: in_valid gaps carrying inverted junk bits
        send_frame(7'b0110011, 4'b1011, 1'b0, 3);
        drain("t5_drain");

        // 6: reset after bit 4 discards the frame
        part = 7'b1111111;
        for (int i = 6; i >= 3; i--) drive_bit(part[i], i == 6);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        model_cnt = 0;
        chk("t6_rst_out", int'(out), 0);
        chk("t6_rst_cnt", int'(err_cnt), 0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        send_frame(7'b0110011, 4'b1011, 1'b0, 0);
        drain("t6_clean_drain");

        // 6b: saturation, four errored frames
        send_frame(7'b1110011, 4'b1011, 1'b1, 0);
        send_frame(7'b0100011, 4'b1011, 1'b1, 0);
        send_frame(7'b1111110, 4'b1111, 1'b1, 0);
        send_frame(7'b0001000, 4'b0000, 1'b1, 0);
        drain("t6_sat_drain");
`ifdef HAMMING_RX_ERRCNT_EN
        chk("t6_sat_cnt", int'(err_cnt), 3);
`else
        chk("t6_sat_cnt", int'(err_cnt), 0);
`endif
        chk("t6_out_hold", int'(out), 0);
        chk("final_sync_count", sync_seen, 1);
        chk("valid_count", vq.size(), pushes);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
